cam_pixel_packer: RTL

- Downstream of the camera interface. Samples raw OV-style camera signals (Vsync, Href, Pclk, 8-bit data) in the system clock domain.
- Packs each RGB565 byte pair into one RGB332 byte.
- Generates a linear frame-buffer address and a single-cycle write strobe for the picture RAM.
- Captures one frame per arm, or frames back-to-back while armed, and flags frame completion and geometry errors.

---
 rtl/cam_pixel_packer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_packer.sv
// Samples OV-style camera signals in the system clock domain, packs RGB565 pairs to RGB332 and writes a linear frame buffer.
// Optional CAM_DOWNSCALE_EN: 2:1 decimation in both axes before storage.
module cam_pixel_packer #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pclk,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              geom_err
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0] X_LIM = XW'(H_PIX);
    localparam logic [YW-1:0] Y_LIM = YW'(V_LINES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [1:0] vsync_ff, href_ff, pclk_ff;
    logic [7:0] data_meta, data_sync;
    logic       vsync_prev, href_prev, pclk_prev;
    logic       vsync_sync, href_sync, pclk_sync;
    logic       pclk_rise, vsync_fall, vsync_rise, href_fall;
    logic       start_frame;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic              phase;
    logic [5:0]        hi_bits;
    logic              pix_keep, line_keep, in_range;

    assign vsync_sync = vsync_ff[1];
    assign href_sync  = href_ff[1];
    assign pclk_sync  = pclk_ff[1];

    // Data shares the pclk pipeline depth so data_sync is the byte of the detected edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_ff   <= '0;
            href_ff    <= '0;
            pclk_ff    <= '0;
            data_meta  <= '0;
            data_sync  <= '0;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
            pclk_prev  <= 1'b0;
        end else begin
            vsync_ff   <= {vsync_ff[0], cam_vsync};
            href_ff    <= {href_ff[0], cam_href};
            pclk_ff    <= {pclk_ff[0], cam_pclk};
            data_meta  <= cam_data;
            data_sync  <= data_meta;
            vsync_prev <= vsync_sync;
            href_prev  <= href_sync;
            pclk_prev  <= pclk_sync;
        end
    end

    assign pclk_rise  = pclk_sync & ~pclk_prev;
    assign vsync_fall = ~vsync_sync & vsync_prev;
    assign vsync_rise = vsync_sync & ~vsync_prev;
    assign href_fall  = ~href_sync & href_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) state_next = WAIT_VS;
            end
            WAIT_VS: begin
                if (!capture_en) begin
                    state_next = IDLE;
                end else if (vsync_fall) begin
                    state_next  = CAPTURE;
                    start_frame = 1'b1;
                end
            end
            CAPTURE: begin
                if (vsync_rise) state_next = DONE;
            end
            DONE: begin
                state_next = capture_en ? WAIT_VS : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state == WAIT_VS) || (state == CAPTURE);
    assign frame_done = (state == DONE);

`ifdef CAM_DOWNSCALE_EN
    logic x_odd, y_odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_odd <= 1'b0;
            y_odd <= 1'b0;
        end else if (start_frame) begin
            x_odd <= 1'b0;
            y_odd <= 1'b0;
        end else if (state == CAPTURE) begin
            if (href_fall) begin
                x_odd <= 1'b0;
                y_odd <= ~y_odd;
            end else if (pclk_rise && href_sync && phase) begin
                x_odd <= ~x_odd;
            end
        end
    end

    always_comb begin
        line_keep = ~y_odd;
        pix_keep  = ~x_odd & ~y_odd;
    end
`else
    always_comb begin
        line_keep = 1'b1;
        pix_keep  = 1'b1;
    end
`endif

    assign in_range = (x < X_LIM) && (y < Y_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            geom_err <= 1'b0;
            x        <= '0;
            y        <= '0;
            addr     <= '0;
            phase    <= 1'b0;
            hi_bits  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_frame) begin
                x     <= '0;
                y     <= '0;
                addr  <= '0;
                phase <= 1'b0;
            end else if (state == CAPTURE) begin
                // Line end wins over a coincident pclk edge; a half pixel is dropped here.
                if (href_fall) begin
                    if (line_keep && (y < Y_LIM)) y <= y + YW'(1);
                    x     <= '0;
                    phase <= 1'b0;
                end else if (pclk_rise && href_sync) begin
                    if (!phase) begin
                        hi_bits <= {data_sync[7:5], data_sync[2:0]};
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (pix_keep) begin
                            if (x < X_LIM) x <= x + XW'(1);
                            if (in_range) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= {hi_bits, data_sync[4:3]};
                                addr    <= addr + ADDR_W'(1);
                            end else begin
                                geom_err <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
